// File: rtl/updown_dir_decoder.sv
// Up/down counter direction decoder: classifies each counter sample as up, down, hold or illegal jump.
// Optional UPDOWN_DIR_ZERO_RESYNC_EN: a jump to 0 is a counter reset (resync pulse), not an error.
// Ports: clk, rst (sync, active-high), cnt_in/cnt_valid in; dir_valid, dir, hold, err,
//        err_sticky, run_len, primed (+ resync when enabled) out, all registered.
module updown_dir_decoder #(
  parameter int WIDTH = 4,
  parameter int RUN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             cnt_valid,
  output logic             dir_valid,
  output logic             dir,
  output logic             hold,
  output logic             err,
  output logic             err_sticky,
  output logic [RUN_W-1:0] run_len,
`ifdef UPDOWN_DIR_ZERO_RESYNC_EN
  output logic             resync,
`endif
  output logic             primed
);

  typedef enum logic {
    S_UNPRIMED = 1'b0,
    S_TRACK    = 1'b1
  } state_t;

  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_prev, w_prev_n;
  logic             r_ld_vld, w_ld_vld_n;
  logic             r_ld, w_ld_n;
  logic             r_dv, w_dv_n;
  logic             r_dir, w_dir_n;
  logic             r_hold, w_hold_n;
  logic             r_err, w_err_n;
  logic             r_stk, w_stk_n;
  logic             r_rsy, w_rsy_n;
  logic [RUN_W-1:0] r_run, w_run_n;

  logic [WIDTH-1:0] w_delta;
  logic             w_up, w_dn, w_zero;
  logic             w_step, w_sdir;

  assign w_delta = cnt_in - r_prev;
  // For WIDTH=1 a delta of 1 is both +1 and -1; up wins.
  assign w_up    = (w_delta == WIDTH'(1));
  assign w_dn    = (w_delta == '1) && !w_up;
  assign w_zero  = (w_delta == '0);
  assign w_step  = w_up || w_dn;
  assign w_sdir  = w_up;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_UNPRIMED;
      r_prev   <= '0;
      r_ld_vld <= 1'b0;
      r_ld     <= 1'b0;
      r_dv     <= 1'b0;
      r_dir    <= 1'b0;
      r_hold   <= 1'b0;
      r_err    <= 1'b0;
      r_stk    <= 1'b0;
      r_rsy    <= 1'b0;
      r_run    <= '0;
    end else begin
      r_state  <= w_state_n;
      r_prev   <= w_prev_n;
      r_ld_vld <= w_ld_vld_n;
      r_ld     <= w_ld_n;
      r_dv     <= w_dv_n;
      r_dir    <= w_dir_n;
      r_hold   <= w_hold_n;
      r_err    <= w_err_n;
      r_stk    <= w_stk_n;
      r_rsy    <= w_rsy_n;
      r_run    <= w_run_n;
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_prev_n   = r_prev;
    w_ld_vld_n = r_ld_vld;
    w_ld_n     = r_ld;
    w_dv_n     = 1'b0;
    w_dir_n    = r_dir;
    w_hold_n   = 1'b0;
    w_err_n    = 1'b0;
    w_stk_n    = r_stk;
    w_rsy_n    = 1'b0;
    w_run_n    = r_run;
    unique case (r_state)
      S_UNPRIMED: begin
        if (cnt_valid) begin
          w_prev_n  = cnt_in;
          w_state_n = S_TRACK;
        end
      end
      S_TRACK: begin
        if (cnt_valid) begin
          w_prev_n = cnt_in;
          w_dv_n   = 1'b1;
          unique case (1'b1)
            w_step: begin
              w_dir_n = w_sdir;
              if (r_ld_vld && (r_ld == w_sdir)) begin
                if (r_run != '1) w_run_n = r_run + 1'b1;
              end else begin
                w_run_n    = RUN_W'(1);
                w_ld_vld_n = 1'b1;
                w_ld_n     = w_sdir;
              end
            end
            w_zero: begin
              w_hold_n = 1'b1;
            end
            default: begin
              w_run_n    = '0;
              w_ld_vld_n = 1'b0;
`ifdef UPDOWN_DIR_ZERO_RESYNC_EN
              if (cnt_in == '0) begin
                w_rsy_n = 1'b1;
              end else begin
                w_err_n = 1'b1;
                w_stk_n = 1'b1;
              end
`else
              w_err_n = 1'b1;
              w_stk_n = 1'b1;
`endif
            end
          endcase
        end
      end
      default: w_state_n = S_UNPRIMED;
    endcase
  end

  assign dir_valid  = r_dv;
  assign dir        = r_dir;
  assign hold       = r_hold;
  assign err        = r_err;
  assign err_sticky = r_stk;
  assign run_len    = r_run;
  assign primed     = (r_state == S_TRACK);
`ifdef UPDOWN_DIR_ZERO_RESYNC_EN
  assign resync     = r_rsy;
`else
  logic w_unused;
  assign w_unused = r_rsy;
`endif

endmodule

// File: tb/tb_updown_dir_decoder.sv
// Scoreboard bench for updown_dir_decoder: integer reference model feeds an
// expected-result queue; a negedge monitor pops and compares on dir_valid.
module tb_updown_dir_decoder;

  localparam int W   = 4;
  localparam int RW  = 8;
  localparam int MOD = 1 << W;
  localparam int SAT = (1 << RW) - 1;

  logic          clk = 0;
  logic          rst = 1;
  logic [W-1:0]  cnt_in = '0;
  logic          cnt_valid = 0;
  logic          dir_valid, dir, hold, err, err_sticky, primed;
  logic [RW-1:0] run_len;
  logic          rsy;

`ifdef UPDOWN_DIR_ZERO_RESYNC_EN
  localparam bit RSY_EN = 1;
`else
  localparam bit RSY_EN = 0;
  assign rsy = 1'b0;
`endif

  updown_dir_decoder #(.WIDTH(W), .RUN_W(RW)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .cnt_valid(cnt_valid),
    .dir_valid(dir_valid), .dir(dir), .hold(hold), .err(err),
    .err_sticky(err_sticky), .run_len(run_len),
`ifdef UPDOWN_DIR_ZERO_RESYNC_EN
    .resync(rsy),
`endif
    .primed(primed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          dir;
    logic          hold;
    logic          err;
    logic          stk;
    logic          rsy;
    logic [RW-1:0] run;
  } res_t;

  res_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model state (plain integers)
  bit m_primed;
  int m_prev;
  int m_last;   // +1 up, -1 down, 0 none
  int m_run;
  bit m_dir;
  bit m_stk;

  function automatic void m_reset();
    m_primed = 0; m_prev = 0; m_last = 0;
    m_run = 0; m_dir = 0; m_stk = 0;
  endfunction

  function automatic void m_step(input int s);
    if (m_last == s) m_run = (m_run + 1 > SAT) ? SAT : m_run + 1;
    else begin m_run = 1; m_last = s; end
    m_dir = (s > 0);
  endfunction

  function automatic void m_sample(input int v);
    int   d;
    res_t r;
    if (!m_primed) begin
      m_primed = 1; m_prev = v; return;
    end
    d = ((v - m_prev) % MOD + MOD) % MOD;
    r = '0;
    if (d == 1) m_step(1);
    else if (d == MOD - 1) m_step(-1);
    else if (d == 0) r.hold = 1;
    else if (RSY_EN && v == 0) begin
      r.rsy = 1; m_run = 0; m_last = 0;
    end else begin
      r.err = 1; m_run = 0; m_last = 0; m_stk = 1;
    end
    m_prev = v;
    r.dir = m_dir; r.stk = m_stk; r.run = RW'(m_run);
    q.push_back(r);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    res_t a, e;
    if (dir_valid) begin
      a = '{dir, hold, err, err_sticky, rsy, run_len};
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got %h expected none", a);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL result: got dir=%b hold=%b err=%b stk=%b rsy=%b run=%0d expected dir=%b hold=%b err=%b stk=%b rsy=%b run=%0d",
                   a.dir, a.hold, a.err, a.stk, a.rsy, a.run,
                   e.dir, e.hold, e.err, e.stk, e.rsy, e.run);
        end
      end
    end else if (!rst) begin
      n_tests++;
      if (hold || err || rsy) begin
        n_fail++;
        $display("FAIL idle_pulse: got hold=%b err=%b rsy=%b expected 0",
                 hold, err, rsy);
      end
    end
  end

  // stimulus; called at posedge+1, leaves at next posedge+1
  task automatic send(input int v, input bit with_rst = 0);
    cnt_in    = W'(v);
    cnt_valid = 1;
    rst       = with_rst;
    if (with_rst) m_reset();
    else m_sample(v);
    @(posedge clk); #1;
    cnt_valid = 0;
    rst       = 0;
    cnt_in    = W'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1; m_reset();
    idle(2);
    rst = 0;
  endtask

  task automatic seq(input int vals[$]);
    foreach (vals[i]) send(vals[i]);
  endtask

  initial begin
    int last_v;
    m_reset();
    idle(3);
    check("rst_dir_valid", dir_valid, 0);
    check("rst_primed", primed, 0);
    check("rst_run_len", run_len, 0);
    check("rst_sticky", err_sticky, 0);
    check("rst_dir", dir, 0);
    rst = 0;

    // first sample primes only
    send(5);
    check("prime_primed", primed, 1);
    check("prime_no_pulse", dir_valid, 0);
    send(6);
    idle(2);

    do_reset();
    seq('{13, 14, 15, 0, 1});
    idle(2);

    do_reset();
    seq('{3, 2, 2, 1, 2});
    idle(2);

    do_reset();
    seq('{4, 9});
    check("jump_sticky", err_sticky, 1);
    send(10);
    idle(1);
    check("sticky_holds", err_sticky, 1);

    do_reset();
    seq('{7, 0});
    check("resync_sticky", err_sticky, RSY_EN ? 0 : 1);
    idle(2);

    // reset mid-stream with a sample in the same cycle
    do_reset();
    seq('{2, 3, 4});
    send(5, 1);
    check("mid_rst_primed", primed, 0);
    check("mid_rst_run", run_len, 0);
    check("mid_rst_dir", dir, 0);
    send(6);
    check("mid_rst_reprime", primed, 1);
    idle(2);

    // saturation of run_len over a long up run with gaps
    do_reset();
    for (int i = 0; i < SAT + 20; i++) begin
      send(i % MOD);
      if (i % 37 == 0) idle(1);
    end
    idle(2);
    check("sat_run", run_len, SAT);

    // randomized traffic
    do_reset();
    last_v = 0;
    for (int i = 0; i < 3000; i++) begin
      int r, v;
      r = $urandom_range(0, 99);
      if (r < 35) v = (last_v + 1) % MOD;
      else if (r < 65) v = (last_v + MOD - 1) % MOD;
      else if (r < 75) v = last_v;
      else if (r < 85) v = 0;
      else v = $urandom_range(0, MOD - 1);
      if ($urandom_range(0, 99) < 2) send(v, 1);
      else send(v);
      last_v = v;
      if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    check("queue_drained", q.size(), 0);
    check("final_sticky", err_sticky, m_stk);
    check("final_run", run_len, m_run);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_dir_decoder.md
Name: updown_dir_decoder

Overview:
- Observes the sampled output of an up/down counter and recovers, per valid sample, the step direction that produced it (up, down, hold or illegal jump).
- Decoder counterpart of the up/down counter's `ctrl` input. Used as an on-chip monitor and as a bench-side golden checker for counter blocks.
- One registered result per accepted sample; also tracks same-direction run length and a sticky error flag.

Parameters:
- WIDTH, 4: width of the observed count; all delta arithmetic is modulo 2^WIDTH.
- RUN_W, 8: width of the run-length output; run_len saturates at 2^RUN_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- cnt_in  input  WIDTH  observed counter value.
- cnt_valid  input  1  cnt_in is a new sample this cycle.
- dir_valid  output  1  one-cycle pulse: dir/hold/err below are valid.
- dir  output  1  1 = up (+1), 0 = down (-1); meaningful only when dir_valid=1 and hold=0 and err=0.
- hold  output  1  sample equal to the previous sample.
- err  output  1  delta not in {-1, 0, +1}.
- err_sticky  output  1  set on any err pulse; cleared only by rst.
- run_len  output  RUN_W  consecutive same-direction steps including the current one.
- primed  output  1  a reference sample is held.

Behaviour:
- Reset (rst=1 at a rising edge):
  - Outputs: dir_valid=0, dir=0, hold=0, err=0, err_sticky=0, run_len=0, primed=0.
  - Internal: prev=0, last_dir invalid, state UNPRIMED.
  - rst has priority over cnt_valid in the same cycle; that sample is discarded.
- State machine, two states:
  - UNPRIMED: a cycle with cnt_valid=1 stores prev=cnt_in, sets primed=1 and moves to TRACK. No dir_valid pulse is produced.
  - TRACK: each cycle with cnt_valid=1 computes delta = cnt_in - prev (mod 2^WIDTH), then sets prev=cnt_in.
  - TRACK has no exit other than rst.
- Classification, registered; results appear the cycle after the sample with dir_valid=1:
  - delta==1: dir=1, hold=0, err=0.
  - delta==2^WIDTH-1: dir=0, hold=0, err=0.
  - delta==0: hold=1, err=0, dir keeps its previous value.
  - Any other delta: err=1, hold=0, dir keeps its previous value; err_sticky is set.
- Wrap-around is legal:
  - 2^WIDTH-1 -> 0 is up.
  - 0 -> 2^WIDTH-1 is down.
- Run length:
  - Step in the same direction as last_dir: run_len+1, saturating at 2^RUN_W-1.
  - Step in the opposite direction, or last_dir invalid: run_len=1, last_dir updated.
  - hold: run_len and last_dir unchanged.
  - err: run_len=0, last_dir invalid.
- Pulse timing:
  - cnt_valid=0 cycles: dir_valid, hold and err return to 0 the following cycle.
  - dir, run_len, err_sticky and primed hold their values.
- Back-to-back samples (cnt_valid high every cycle) are fully supported at one result per cycle. Latency is fixed at 1 cycle.
- WIDTH=1 is legal: deltas are only 0 or 1, and 1 is classified as up.

Optional Feature:
- Macro: UPDOWN_DIR_ZERO_RESYNC_EN.
- When defined:
  - A sample in TRACK with cnt_in==0 and delta not in {-1, 0, +1} is treated as an observed counter reset, not an error.
  - Response: dir_valid=1, err=0, hold=0, run_len=0, last_dir invalid, prev=0.
  - Extra output port resync (1 bit) pulses for that one cycle. resync reset value is 0.
- When undefined:
  - The resync port does not exist.
  - Such a jump is an ordinary err (err=1, err_sticky set).

Test Plan:
- First sample after reset: rst, then cnt_valid with cnt_in=5 -> no dir_valid, primed=1. Next sample 6 -> dir_valid=1, dir=1, run_len=1 one cycle later.
- Up run across wrap: samples 13,14,15,0,1 -> four results with dir=1, run_len=1,2,3,4, err=0.
- Direction change and hold: samples 3,2,2,1,2 -> results: down run_len=1; hold run_len=1; down run_len=2; up run_len=1.
- Illegal jump: samples 4,9 -> err=1, err_sticky=1, run_len=0. Then 10 -> up, run_len=1, err=0, err_sticky stays 1.
- Resync option: samples 7,0.
  - With UPDOWN_DIR_ZERO_RESYNC_EN: resync=1, err=0, err_sticky=0.
  - Without it: err=1, err_sticky=1.
- Reset mid-stream: rst asserted together with cnt_valid during an up run -> next cycle all outputs 0, primed=0. The following sample only primes, with no dir_valid pulse.
